// File: rtl/lcd_bus_responder.sv
// HD44780-style LCD responder: samples the E/RS/RW/DB bus, decodes writes on each
// E falling edge, models busy timing and exposes the decoded display state.
module lcd_bus_responder #(
  parameter int unsigned POWER_ON_CYCLES = 4000,
  parameter int unsigned BUSY_SHORT      = 3,
  parameter int unsigned BUSY_CLEAR      = 152
) (
  input  logic       clk_1024,
  input  logic       reset_n,
  input  logic       E_lcd,
  input  logic       RS_lcd,
  input  logic       RW_lcd,
  input  logic [7:0] data_lcd_in,
  output logic [7:0] data_lcd_out,
  output logic       data_lcd_oe,
  output logic       ready,
  output logic       busy,
  output logic       violation,
  output logic       char_strobe,
  output logic [7:0] char_code,
  output logic [6:0] char_addr,
  output logic [6:0] ddram_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       dl_8bit,
  output logic       two_line,
  output logic       font_5x10,
  output logic       cfg_valid
);

  localparam int unsigned PO_W     = $clog2(POWER_ON_CYCLES + 1);
  localparam int unsigned BUSY_MAX = (BUSY_CLEAR > BUSY_SHORT) ? BUSY_CLEAR : BUSY_SHORT;
  localparam int unsigned BUSY_W   = $clog2(BUSY_MAX + 1);
  localparam logic [PO_W-1:0]   PO_LAST      = PO_W'(POWER_ON_CYCLES - 1);
  localparam logic [BUSY_W-1:0] BUSY_SHORT_V = BUSY_W'(BUSY_SHORT);
  localparam logic [BUSY_W-1:0] BUSY_CLEAR_V = BUSY_W'(BUSY_CLEAR);

  typedef enum logic {
    PH_POWER_ON = 1'b0,
    PH_READY    = 1'b1
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [PO_W-1:0]   po_cnt_q, po_cnt_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              e_q, rs_q, rw_q;
  logic [7:0]        d_q;
  logic [7:0]        data_lcd_out_q, data_lcd_out_d;
  logic              violation_q, violation_d;
  logic              char_strobe_q, char_strobe_d;
  logic [7:0]        char_code_q, char_code_d;
  logic [6:0]        char_addr_q, char_addr_d;
  logic [6:0]        ddram_addr_q, ddram_addr_d;
  logic              disp_on_q, disp_on_d, cursor_on_q, cursor_on_d, blink_on_q, blink_on_d;
  logic              inc_mode_q, inc_mode_d, shift_mode_q, shift_mode_d;
  logic              dl_8bit_q, dl_8bit_d, two_line_q, two_line_d, font_5x10_q, font_5x10_d;
  logic              seen_fs_q, seen_fs_d, seen_clr_q, seen_clr_d, seen_em_q, seen_em_d;

  logic busy_flag, fall, write_acc;

  // Line 1 occupies 0x00-0x27 and line 2 0x40-0x67 in two-line mode; one line is 0x00-0x4F.
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up, input logic two);
    logic [6:0] r;
    if (up) begin
      if (two && a == 7'h27)       r = 7'h40;
      else if (two && a == 7'h67)  r = 7'h00;
      else if (!two && a == 7'h4F) r = 7'h00;
      else                         r = a + 7'd1;
    end else begin
      if (two && a == 7'h40)       r = 7'h27;
      else if (two && a == 7'h00)  r = 7'h67;
      else if (!two && a == 7'h00) r = 7'h4F;
      else                         r = a - 7'd1;
    end
    return r;
  endfunction

  assign busy_flag = (busy_cnt_q != '0);
  assign fall      = e_q & ~E_lcd;
  assign write_acc = fall & ~rw_q & (phase_q == PH_READY) & ~busy_flag;

  always_comb begin
    phase_d        = phase_q;
    po_cnt_d       = po_cnt_q;
    busy_cnt_d     = busy_flag ? busy_cnt_q - BUSY_W'(1) : '0;
    violation_d    = 1'b0;
    char_strobe_d  = 1'b0;
    char_code_d    = char_code_q;
    char_addr_d    = char_addr_q;
    ddram_addr_d   = ddram_addr_q;
    disp_on_d      = disp_on_q;
    cursor_on_d    = cursor_on_q;
    blink_on_d     = blink_on_q;
    inc_mode_d     = inc_mode_q;
    shift_mode_d   = shift_mode_q;
    dl_8bit_d      = dl_8bit_q;
    two_line_d     = two_line_q;
    font_5x10_d    = font_5x10_q;
    seen_fs_d      = seen_fs_q;
    seen_clr_d     = seen_clr_q;
    seen_em_d      = seen_em_q;
    data_lcd_out_d = '0;

    if (phase_q == PH_POWER_ON) begin
      po_cnt_d = po_cnt_q + PO_W'(1);
      if (po_cnt_q == PO_LAST) phase_d = PH_READY;
    end

    if (fall && !rw_q && !write_acc) violation_d = 1'b1;

    if (write_acc) begin
      if (rs_q) begin
        char_strobe_d = 1'b1;
        char_code_d   = d_q;
        char_addr_d   = ddram_addr_q;
        ddram_addr_d  = step_addr(ddram_addr_q, inc_mode_q, two_line_q);
        busy_cnt_d    = BUSY_SHORT_V;
      end else begin
        casez (d_q)
          8'b1???????: begin
            ddram_addr_d = d_q[6:0];
            busy_cnt_d   = BUSY_SHORT_V;
          end
          8'b01??????: busy_cnt_d = BUSY_SHORT_V;
          8'b001?????: begin
            dl_8bit_d   = d_q[4];
            two_line_d  = d_q[3];
            font_5x10_d = d_q[2];
            seen_fs_d   = 1'b1;
            busy_cnt_d  = BUSY_SHORT_V;
          end
          8'b0001????: begin
            if (!d_q[3]) ddram_addr_d = step_addr(ddram_addr_q, d_q[2], two_line_q);
            busy_cnt_d = BUSY_SHORT_V;
          end
          8'b00001???: begin
            disp_on_d   = d_q[2];
            cursor_on_d = d_q[1];
            blink_on_d  = d_q[0];
            busy_cnt_d  = BUSY_SHORT_V;
          end
          8'b000001??: begin
            inc_mode_d   = d_q[1];
            shift_mode_d = d_q[0];
            seen_em_d    = 1'b1;
            busy_cnt_d   = BUSY_SHORT_V;
          end
          8'b0000001?: begin
            ddram_addr_d = '0;
            busy_cnt_d   = BUSY_CLEAR_V;
          end
          8'b00000001: begin
            ddram_addr_d = '0;
            inc_mode_d   = 1'b1;
            seen_clr_d   = 1'b1;
            busy_cnt_d   = BUSY_CLEAR_V;
          end
          default: ;
        endcase
      end
    end

    // Read data tracks the live bus so it lines up with data_lcd_oe from the sampled strobe.
    if (E_lcd && RW_lcd) data_lcd_out_d = RS_lcd ? char_code_q : {busy_flag, ddram_addr_q};
  end

  always_ff @(posedge clk_1024 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q        <= PH_POWER_ON;
      po_cnt_q       <= '0;
      busy_cnt_q     <= '0;
      e_q            <= 1'b0;
      rs_q           <= 1'b0;
      rw_q           <= 1'b0;
      d_q            <= '0;
      data_lcd_out_q <= '0;
      violation_q    <= 1'b0;
      char_strobe_q  <= 1'b0;
      char_code_q    <= '0;
      char_addr_q    <= '0;
      ddram_addr_q   <= '0;
      disp_on_q      <= 1'b0;
      cursor_on_q    <= 1'b0;
      blink_on_q     <= 1'b0;
      inc_mode_q     <= 1'b1;
      shift_mode_q   <= 1'b0;
      dl_8bit_q      <= 1'b1;
      two_line_q     <= 1'b0;
      font_5x10_q    <= 1'b0;
      seen_fs_q      <= 1'b0;
      seen_clr_q     <= 1'b0;
      seen_em_q      <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      po_cnt_q       <= po_cnt_d;
      busy_cnt_q     <= busy_cnt_d;
      e_q            <= E_lcd;
      rs_q           <= RS_lcd;
      rw_q           <= RW_lcd;
      d_q            <= data_lcd_in;
      data_lcd_out_q <= data_lcd_out_d;
      violation_q    <= violation_d;
      char_strobe_q  <= char_strobe_d;
      char_code_q    <= char_code_d;
      char_addr_q    <= char_addr_d;
      ddram_addr_q   <= ddram_addr_d;
      disp_on_q      <= disp_on_d;
      cursor_on_q    <= cursor_on_d;
      blink_on_q     <= blink_on_d;
      inc_mode_q     <= inc_mode_d;
      shift_mode_q   <= shift_mode_d;
      dl_8bit_q      <= dl_8bit_d;
      two_line_q     <= two_line_d;
      font_5x10_q    <= font_5x10_d;
      seen_fs_q      <= seen_fs_d;
      seen_clr_q     <= seen_clr_d;
      seen_em_q      <= seen_em_d;
    end
  end

  assign data_lcd_out = data_lcd_out_q;
  assign data_lcd_oe  = e_q & rw_q;
  assign ready        = (phase_q == PH_READY);
  assign busy         = busy_flag;
  assign violation    = violation_q;
  assign char_strobe  = char_strobe_q;
  assign char_code    = char_code_q;
  assign char_addr    = char_addr_q;
  assign ddram_addr   = ddram_addr_q;
  assign disp_on      = disp_on_q;
  assign cursor_on    = cursor_on_q;
  assign blink_on     = blink_on_q;
  assign inc_mode     = inc_mode_q;
  assign shift_mode   = shift_mode_q;
  assign dl_8bit      = dl_8bit_q;
  assign two_line     = two_line_q;
  assign font_5x10    = font_5x10_q;
  assign cfg_valid    = seen_fs_q & seen_clr_q & seen_em_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: char writes go through a scoreboard queue,
// everything else is checked against values worked out from the bus protocol.
module tb_lcd_bus_responder;

  logic       clk_1024 = 1'b0;
  logic       reset_n;
  logic       E_lcd, RS_lcd, RW_lcd;
  logic [7:0] data_lcd_in;
  logic [7:0] data_lcd_out;
  logic       data_lcd_oe, ready, busy, violation, char_strobe;
  logic [7:0] char_code;
  logic [6:0] char_addr, ddram_addr;
  logic       disp_on, cursor_on, blink_on, inc_mode, shift_mode;
  logic       dl_8bit, two_line, font_5x10, cfg_valid;

  typedef struct packed {
    logic [7:0] code;
    logic [6:0] addr;
  } cw_t;

  cw_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  vio_seen = 0;
  int  exp_vio = 0;
  int  n;

  lcd_bus_responder #(
    .POWER_ON_CYCLES(4000),
    .BUSY_SHORT(3),
    .BUSY_CLEAR(152)
  ) dut (
    .clk_1024(clk_1024), .reset_n(reset_n), .E_lcd(E_lcd), .RS_lcd(RS_lcd), .RW_lcd(RW_lcd),
    .data_lcd_in(data_lcd_in), .data_lcd_out(data_lcd_out), .data_lcd_oe(data_lcd_oe),
    .ready(ready), .busy(busy), .violation(violation), .char_strobe(char_strobe),
    .char_code(char_code), .char_addr(char_addr), .ddram_addr(ddram_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .inc_mode(inc_mode), .shift_mode(shift_mode), .dl_8bit(dl_8bit),
    .two_line(two_line), .font_5x10(font_5x10), .cfg_valid(cfg_valid)
  );

  always #5 clk_1024 = ~clk_1024;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    cw_t e;
    @(posedge clk_1024);
    #1;
    cyc++;
    if (violation === 1'b1) vio_seen++;
    if (char_strobe === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL sb_unexpected_strobe observed=0x%0h expected=none", char_code);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_code", char_code, e.code);
        chk("sb_addr", char_addr, e.addr);
      end
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    RS_lcd = rs; RW_lcd = 1'b0; data_lcd_in = d; E_lcd = 1'b1;
    tick();
    E_lcd = 1'b0;
    tick();
  endtask

  task automatic read_start(input logic rs);
    RS_lcd = rs; RW_lcd = 1'b1; E_lcd = 1'b1;
    tick();
  endtask

  task automatic read_end();
    E_lcd = 1'b0;
    tick();
    RW_lcd = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int k = 0;
    while (busy === 1'b1 && k < 1000) begin
      tick();
      k++;
    end
    chk(tag, k, exp_cycles);
  endtask

  task automatic put_char(input logic [7:0] code, input logic [6:0] addr);
    cw_t e;
    e.code = code;
    e.addr = addr;
    exp_q.push_back(e);
    bus_write(1'b1, code);
  endtask

  initial begin
    reset_n = 1'b0; E_lcd = 1'b0; RS_lcd = 1'b0; RW_lcd = 1'b0; data_lcd_in = '0;
    tick(); tick();
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inc", inc_mode, 1);
    chk("rst_dl", dl_8bit, 1);
    chk("rst_cfg", {two_line, font_5x10, disp_on, cursor_on, blink_on, shift_mode, cfg_valid}, 0);
    chk("rst_addr", ddram_addr, 0);
    chk("rst_oe_out", {data_lcd_oe, data_lcd_out}, 0);
    chk("rst_pulses", {violation, char_strobe}, 0);

    reset_n = 1'b1;
    cyc = 0;
    while (cyc < 98) tick();
    bus_write(1'b0, 8'h38);
    exp_vio++;
    chk("pre_ready_vio", violation, 1);
    chk("pre_ready_two_line", two_line, 0);

    while (cyc < 3998) tick();
    chk("ready_low_3998", ready, 0);
    bus_write(1'b0, 8'h38);
    exp_vio++;
    chk("ready_high_4000", ready, 1);
    chk("ready_edge_vio", violation, 1);
    chk("ready_edge_two_line", two_line, 0);
    tick();
    chk("vio_one_cycle", violation, 0);

    bus_write(1'b0, 8'h38);
    chk("fs_bits", {dl_8bit, two_line, font_5x10}, 3'b110);
    chk("fs_busy", busy, 1);
    wait_idle("busy_short_len", 3);
    bus_write(1'b0, 8'h0E);
    chk("dispctl", {disp_on, cursor_on, blink_on}, 3'b110);
    wait_idle("busy_dispctl", 3);
    bus_write(1'b0, 8'h01);
    chk("clear_addr", ddram_addr, 0);
    wait_idle("busy_clear_len", 152);
    bus_write(1'b0, 8'h06);
    chk("entry", {inc_mode, shift_mode}, 2'b10);
    chk("cfg_valid", cfg_valid, 1);
    wait_idle("busy_entry", 3);
    chk("init_no_vio", vio_seen, exp_vio);

    bus_write(1'b0, 8'hA7);  chk("set_27", ddram_addr, 7'h27); wait_idle("w0", 3);
    put_char(8'h41, 7'h27);
    chk("wr_strobe", char_strobe, 1);
    chk("wr_code", char_code, 8'h41);
    chk("wr_addr", char_addr, 7'h27);
    chk("wrap_27_40", ddram_addr, 7'h40);
    wait_idle("w1", 3);
    put_char(8'h42, 7'h40);  chk("inc_41", ddram_addr, 7'h41); wait_idle("w2", 3);
    tick();
    chk("strobe_pulse", char_strobe, 0);
    chk("code_held", char_code, 8'h42);
    bus_write(1'b0, 8'hE7);  wait_idle("w3", 3);
    put_char(8'h43, 7'h67);  chk("wrap_67_00", ddram_addr, 7'h00); wait_idle("w4", 3);
    bus_write(1'b0, 8'h04);  chk("entry_dec", inc_mode, 0); wait_idle("w5", 3);
    put_char(8'h44, 7'h00);  chk("wrap_00_67", ddram_addr, 7'h67); wait_idle("w6", 3);
    bus_write(1'b0, 8'h14);  chk("shift_r_wrap", ddram_addr, 7'h00); wait_idle("w7", 3);
    bus_write(1'b0, 8'h10);  chk("shift_l_wrap", ddram_addr, 7'h67); wait_idle("w8", 3);
    bus_write(1'b0, 8'hC0);  wait_idle("w9", 3);
    bus_write(1'b0, 8'h10);  chk("wrap_40_27", ddram_addr, 7'h27); wait_idle("w10", 3);
    bus_write(1'b0, 8'h18);  chk("disp_shift_keeps", ddram_addr, 7'h27); wait_idle("w11", 3);
    bus_write(1'b0, 8'h00);  chk("nop_no_busy", busy, 0);
    bus_write(1'b0, 8'h06);  wait_idle("w12", 3);
    bus_write(1'b0, 8'h30);  chk("one_line", two_line, 0); wait_idle("w13", 3);
    bus_write(1'b0, 8'hCF);  wait_idle("w14", 3);
    put_char(8'h45, 7'h4F);  chk("wrap_4f_00", ddram_addr, 7'h00); wait_idle("w15", 3);
    bus_write(1'b0, 8'h10);  chk("wrap_00_4f", ddram_addr, 7'h4F); wait_idle("w16", 3);

    read_start(1'b1);
    chk("rd_char_oe", data_lcd_oe, 1);
    chk("rd_char_out", data_lcd_out, 8'h45);
    read_end();
    chk("rd_end", {data_lcd_oe, data_lcd_out}, 0);
    chk("rd_no_busy", busy, 0);
    chk("rd_no_vio", vio_seen, exp_vio);

    bus_write(1'b0, 8'h38);  wait_idle("w17", 3);
    bus_write(1'b0, 8'h0C);
    tick();
    bus_write(1'b0, 8'h0F);
    exp_vio++;
    chk("expiry_edge_vio", violation, 1);
    chk("expiry_edge_keep", {cursor_on, blink_on}, 2'b00);
    bus_write(1'b0, 8'h0F);
    chk("after_expiry_acc", {disp_on, cursor_on, blink_on}, 3'b111);
    wait_idle("w18", 3);

    bus_write(1'b0, 8'h02);
    chk("home_addr", ddram_addr, 0);
    wait_idle("busy_home_len", 152);

    bus_write(1'b0, 8'h04);  wait_idle("w19", 3);
    bus_write(1'b0, 8'h85);  chk("set_05", ddram_addr, 7'h05); wait_idle("w20", 3);
    bus_write(1'b0, 8'h01);
    chk("clear_inc", {inc_mode, ddram_addr}, 8'h80);
    bus_write(1'b0, 8'h30);
    exp_vio++;
    chk("busy_write_vio", violation, 1);
    chk("busy_write_ignored", two_line, 1);
    read_start(1'b0);
    chk("bf_oe", data_lcd_oe, 1);
    chk("bf_out", data_lcd_out, 8'h80);
    read_end();
    wait_idle("busy_clear_rest", 148);
    read_start(1'b0);
    chk("bf_idle_out", {data_lcd_oe, data_lcd_out}, 9'h100);
    read_end();
    chk("vio_count", vio_seen, exp_vio);
    chk("sb_drained", exp_q.size(), 0);

    bus_write(1'b0, 8'h01);
    repeat (5) tick();
    chk("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready_busy", {ready, busy}, 0);
    chk("mid_rst_cfg", {two_line, font_5x10, disp_on, cursor_on, blink_on, shift_mode, cfg_valid}, 0);
    chk("mid_rst_defaults", {inc_mode, dl_8bit}, 2'b11);
    chk("mid_rst_addr_char", {ddram_addr, char_addr, char_code}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
